// File: rtl/boot_loader_ctrl.sv
// Boot sequencer: holds the core in reset, loads a length-prefixed image from UART into BRAM,
// then releases the core and drains its transmit bytes to uart_tx. BOOT_TXQ_EN selects a FIFO TX queue.
module boot_loader_ctrl #(
    parameter int MEM       = 10,
    parameter int LOAD_BASE = 32,
    parameter int TXQ_LOG2  = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_rx_valid,
    input  logic [7:0]       i_rx_data,
    output logic             o_core_rstn,
    input  logic             i_core_memwe,
    input  logic [MEM-1:0]   i_core_memaddr,
    input  logic [31:0]      i_core_memdin,
    output logic [31:0]      o_core_memdout,
    output logic             o_bram_we,
    output logic [MEM-1:0]   o_bram_addr,
    output logic [31:0]      o_bram_din,
    input  logic [31:0]      i_bram_dout,
    input  logic             i_core_tx_ready,
    input  logic [7:0]       i_core_sdata,
    output logic             o_tx_start,
    output logic [7:0]       o_tx_data,
    input  logic             i_tx_busy,
    output logic             o_loading,
    output logic             o_tx_ovf
);

    // state   | meaning
    // ST_LEN  | assembling the 32-bit image word count
    // ST_DATA | assembling image words and writing them to BRAM
    // ST_RUN  | core released, BRAM port passed through to the core
    typedef enum logic [1:0] {ST_LEN, ST_DATA, ST_RUN} state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [1:0]     r_bcnt;
    logic [31:0]    r_shift;
    logic [31:0]    r_n;
    logic [31:0]    r_wcnt;
    logic           r_len_done;
    logic           r_we;
    logic [MEM-1:0] r_addr;
    logic [MEM-1:0] r_bram_addr;
    logic [31:0]    r_bram_din;
    logic           w_rx_take;
    logic [31:0]    w_word;

    // Bytes arriving during the one-cycle decision/write slot are dropped.
    assign w_rx_take = i_rx_valid && (r_state != ST_RUN) && !r_len_done && !r_we;
    assign w_word    = {i_rx_data, r_shift[31:8]};

    always_ff @(posedge clk) begin
        if (!rstn) r_state <= ST_LEN;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt    = r_state;
        o_core_rstn    = 1'b0;
        o_loading      = 1'b1;
        o_bram_we      = r_we;
        o_bram_addr    = r_bram_addr;
        o_bram_din     = r_bram_din;
        o_core_memdout = i_bram_dout;
        case (r_state)
            ST_LEN: begin
                if (r_len_done) w_state_nxt = (r_shift == 32'd0) ? ST_RUN : ST_DATA;
            end
            ST_DATA: begin
                if (r_we && (r_wcnt + 32'd1 == r_n)) w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                o_core_rstn = 1'b1;
                o_loading   = 1'b0;
                o_bram_we   = i_core_memwe;
                o_bram_addr = i_core_memaddr;
                o_bram_din  = i_core_memdin;
            end
            default: w_state_nxt = ST_LEN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_bcnt      <= 2'd0;
            r_shift     <= 32'd0;
            r_n         <= 32'd0;
            r_wcnt      <= 32'd0;
            r_len_done  <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_bram_addr <= '0;
            r_bram_din  <= 32'd0;
        end else begin
            if (w_rx_take) begin
                r_shift <= w_word;
                r_bcnt  <= r_bcnt + 2'd1;
                if (r_bcnt == 2'd3) begin
                    if (r_state == ST_LEN) begin
                        r_len_done <= 1'b1;
                    end else begin
                        r_we        <= 1'b1;
                        r_bram_addr <= r_addr;
                        r_bram_din  <= w_word;
                        r_addr      <= r_addr + 1'b1;
                    end
                end
            end
            if (r_len_done) begin
                r_len_done <= 1'b0;
                r_n        <= r_shift;
                r_addr     <= MEM'(LOAD_BASE);
                r_wcnt     <= 32'd0;
            end
            if (r_we) begin
                r_we   <= 1'b0;
                r_wcnt <= r_wcnt + 32'd1;
            end
        end
    end

    logic       w_push;
    logic       w_pop;
    logic       w_push_ok;
    logic       w_empty;
    logic       w_full;
    logic [7:0] w_head;
    logic       r_start_d;
    logic [7:0] r_tx_data;
    logic       r_ovf;

    assign w_push     = (r_state == ST_RUN) && i_core_tx_ready;
    assign w_pop      = !w_empty && !i_tx_busy && !r_start_d;
    // A pop in the same cycle frees the slot, so a push into a full queue still lands.
    assign w_push_ok  = w_push && (!w_full || w_pop);
    assign o_tx_start = w_pop;
    assign o_tx_data  = w_pop ? w_head : r_tx_data;
    assign o_tx_ovf   = r_ovf;

`ifdef BOOT_TXQ_EN
    localparam int TXQ_DEPTH = 1 << TXQ_LOG2;
    logic [7:0]        r_q [TXQ_DEPTH];
    logic [TXQ_LOG2:0] r_wr;
    logic [TXQ_LOG2:0] r_rd;

    assign w_empty = (r_wr == r_rd);
    assign w_full  = (r_wr[TXQ_LOG2] != r_rd[TXQ_LOG2]) &&
                     (r_wr[TXQ_LOG2-1:0] == r_rd[TXQ_LOG2-1:0]);
    assign w_head  = r_q[r_rd[TXQ_LOG2-1:0]];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (w_push_ok) begin
                r_q[r_wr[TXQ_LOG2-1:0]] <= i_core_sdata;
                r_wr <= r_wr + 1'b1;
            end
            if (w_pop) r_rd <= r_rd + 1'b1;
        end
    end
`else
    logic [7:0] r_hold;
    logic       r_hvalid;

    assign w_empty = !r_hvalid;
    assign w_full  = r_hvalid;
    assign w_head  = r_hold;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_hold   <= 8'd0;
            r_hvalid <= 1'b0;
        end else if (w_push_ok) begin
            r_hold   <= i_core_sdata;
            r_hvalid <= 1'b1;
        end else if (w_pop) begin
            r_hvalid <= 1'b0;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_start_d <= 1'b0;
            r_tx_data <= 8'd0;
            r_ovf     <= 1'b0;
        end else begin
            r_start_d <= w_pop;
            if (w_pop) r_tx_data <= w_head;
            if (w_push && !w_push_ok) r_ovf <= 1'b1;
        end
    end

endmodule

// File: tb/tb_boot_loader_ctrl.sv
// Scoreboard bench for boot_loader_ctrl: expected BRAM writes and TX bytes are queued with the
// stimulus and compared by a negedge monitor; scenario tasks check timing and sticky flags inline.
module tb_boot_loader_ctrl;
    localparam int MEM = 10;
`ifdef BOOT_TXQ_EN
    localparam int QD = 16;
`else
    localparam int QD = 1;
`endif

    logic           clk = 1'b0;
    logic           rstn = 1'b0;
    logic           i_rx_valid = 1'b0;
    logic [7:0]     i_rx_data = 8'd0;
    logic           o_core_rstn;
    logic           i_core_memwe = 1'b0;
    logic [MEM-1:0] i_core_memaddr = '0;
    logic [31:0]    i_core_memdin = 32'd0;
    logic [31:0]    o_core_memdout;
    logic           o_bram_we;
    logic [MEM-1:0] o_bram_addr;
    logic [31:0]    o_bram_din;
    logic [31:0]    i_bram_dout = 32'd0;
    logic           i_core_tx_ready = 1'b0;
    logic [7:0]     i_core_sdata = 8'd0;
    logic           o_tx_start;
    logic [7:0]     o_tx_data;
    logic           i_tx_busy;
    logic           o_loading;
    logic           o_tx_ovf;

    boot_loader_ctrl #(.MEM(MEM), .LOAD_BASE(32), .TXQ_LOG2(4)) dut (
        .clk(clk), .rstn(rstn),
        .i_rx_valid(i_rx_valid), .i_rx_data(i_rx_data),
        .o_core_rstn(o_core_rstn),
        .i_core_memwe(i_core_memwe), .i_core_memaddr(i_core_memaddr), .i_core_memdin(i_core_memdin),
        .o_core_memdout(o_core_memdout),
        .o_bram_we(o_bram_we), .o_bram_addr(o_bram_addr), .o_bram_din(o_bram_din),
        .i_bram_dout(i_bram_dout),
        .i_core_tx_ready(i_core_tx_ready), .i_core_sdata(i_core_sdata),
        .o_tx_start(o_tx_start), .o_tx_data(o_tx_data), .i_tx_busy(i_tx_busy),
        .o_loading(o_loading), .o_tx_ovf(o_tx_ovf)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct { logic [MEM-1:0] addr; logic [31:0] data; } wr_t;
    wr_t        exp_wr[$];
    logic [7:0] exp_tx[$];
    wr_t        mon_w;
    logic [7:0] mon_b;
    logic       prev_start = 1'b0;

    // uart_tx model: busy for 10 cycles starting the cycle after tx_start
    logic busy_stuck = 1'b0;
    int   busy_cnt = 0;
    assign i_tx_busy = busy_stuck || (busy_cnt > 0);
    always @(posedge clk) begin
        if (!rstn)           busy_cnt <= 0;
        else if (o_tx_start) busy_cnt <= 10;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end

    always @(negedge clk) begin
        if (rstn) begin
            if (o_bram_we) begin
                n_checks++;
                if (exp_wr.size() == 0) begin
                    $display("FAIL bram_write_unexpected: got addr=%h din=%h, required no write", o_bram_addr, o_bram_din);
                end else begin
                    mon_w = exp_wr.pop_front();
                    if (o_bram_addr !== mon_w.addr || o_bram_din !== mon_w.data)
                        $display("FAIL bram_write: got addr=%h din=%h, required addr=%h din=%h", o_bram_addr, o_bram_din, mon_w.addr, mon_w.data);
                    else n_pass++;
                end
            end
            if (o_tx_start) begin
                n_checks++;
                if (exp_tx.size() == 0) begin
                    $display("FAIL tx_start_unexpected: got tx_data=%h, required no start", o_tx_data);
                end else begin
                    mon_b = exp_tx.pop_front();
                    if (o_tx_data !== mon_b) $display("FAIL tx_data: got %h, required %h", o_tx_data, mon_b);
                    else n_pass++;
                end
                n_checks++;
                if (prev_start) $display("FAIL tx_back_to_back: got two consecutive starts, required a gap");
                else n_pass++;
            end
        end
        prev_start = o_tx_start;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        i_rx_valid = 1'b1; i_rx_data = b;
        @(posedge clk); #1;
        i_rx_valid = 1'b0;
    endtask

    task automatic strobe_tx(input logic [7:0] b);
        @(posedge clk); #1;
        i_core_tx_ready = 1'b1; i_core_sdata = b;
        @(posedge clk); #1;
        i_core_tx_ready = 1'b0;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        i_rx_valid = 1'b0; i_core_memwe = 1'b0; i_core_tx_ready = 1'b0;
        busy_stuck = 1'b0;
        exp_wr.delete(); exp_tx.delete();
        tick(2);
        rstn = 1'b1;
    endtask

    task automatic goto_run_zero_len();
        for (int i = 0; i < 4; i++) begin send_byte(8'h00); tick(2); end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        tick(2);
        @(negedge clk);
        n_checks++;
        if (o_core_rstn !== 1'b0 || o_loading !== 1'b1) $display("FAIL reset_ctrl: got core_rstn=%b loading=%b, required 0/1", o_core_rstn, o_loading);
        else n_pass++;
        n_checks++;
        if (o_bram_we !== 1'b0 || o_bram_addr !== '0 || o_bram_din !== 32'd0)
            $display("FAIL reset_bram: got we=%b addr=%h din=%h, required 0/0/0", o_bram_we, o_bram_addr, o_bram_din);
        else n_pass++;
        n_checks++;
        if (o_tx_start !== 1'b0 || o_tx_data !== 8'd0 || o_tx_ovf !== 1'b0)
            $display("FAIL reset_tx: got start=%b data=%h ovf=%b, required 0/00/0", o_tx_start, o_tx_data, o_tx_ovf);
        else n_pass++;
        rstn = 1'b1;
    endtask

    task automatic test_load();
        logic [7:0] img[12];
        img = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h6f, 8'h00, 8'h00, 8'h00};
        do_reset();
        exp_wr.push_back('{addr: 10'd32, data: 32'h00100513});
        exp_wr.push_back('{addr: 10'd33, data: 32'h0000006f});
        strobe_tx(8'h99);
        for (int i = 0; i < 11; i++) begin send_byte(img[i]); tick(2); end
        send_byte(img[11]);
        @(negedge clk);
        n_checks++;
        if (o_bram_we !== 1'b1 || o_core_rstn !== 1'b0 || o_loading !== 1'b1)
            $display("FAIL load_last_write: got we=%b core_rstn=%b loading=%b, required 1/0/1", o_bram_we, o_core_rstn, o_loading);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (o_core_rstn !== 1'b1 || o_loading !== 1'b0)
            $display("FAIL load_release: got core_rstn=%b loading=%b, required 1/0", o_core_rstn, o_loading);
        else n_pass++;
        tick(3);
        n_checks++;
        if (exp_wr.size() != 0) $display("FAIL load_writes_seen: got %0d outstanding, required 0", exp_wr.size());
        else n_pass++;
    endtask

    task automatic test_zero_len();
        do_reset();
        for (int i = 0; i < 3; i++) begin send_byte(8'h00); tick(2); end
        send_byte(8'h00);
        @(negedge clk);
        n_checks++;
        if (o_core_rstn !== 1'b0) $display("FAIL zero_len_early: got core_rstn=%b, required 0", o_core_rstn);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (o_core_rstn !== 1'b1 || o_loading !== 1'b0)
            $display("FAIL zero_len_release: got core_rstn=%b loading=%b, required 1/0", o_core_rstn, o_loading);
        else n_pass++;
    endtask

    task automatic test_passthrough();
        i_bram_dout = 32'hCAFEF00D;
        @(posedge clk); #1;
        i_core_memwe = 1'b1; i_core_memaddr = 10'h3FF; i_core_memdin = 32'hDEADBEEF;
        exp_wr.push_back('{addr: 10'h3FF, data: 32'hDEADBEEF});
        @(negedge clk);
        n_checks++;
        if (o_bram_we !== 1'b1 || o_bram_addr !== 10'h3FF) $display("FAIL pass_bram: got we=%b addr=%h, required 1/3ff", o_bram_we, o_bram_addr);
        else n_pass++;
        n_checks++;
        if (o_core_memdout !== 32'hCAFEF00D) $display("FAIL pass_dout: got %h, required cafef00d", o_core_memdout);
        else n_pass++;
        @(posedge clk); #1;
        i_core_memwe = 1'b0;
        send_byte(8'h55);
        tick(3);
        n_checks++;
        if (o_core_rstn !== 1'b1 || exp_wr.size() != 0)
            $display("FAIL run_rx_ignored: got core_rstn=%b pending=%0d, required 1/0", o_core_rstn, exp_wr.size());
        else n_pass++;
    endtask

    task automatic test_tx();
        logic [7:0] msg[3];
        msg = '{8'h41, 8'h42, 8'h43};
        for (int i = 0; i < 3; i++) begin
            exp_tx.push_back(msg[i]);
            strobe_tx(msg[i]);
            tick(15);
        end
        for (int c = 0; c < 200 && exp_tx.size() > 0; c++) @(posedge clk);
        #1;
        n_checks++;
        if (exp_tx.size() != 0) $display("FAIL tx_drain: got %0d bytes unsent, required 0", exp_tx.size());
        else n_pass++;
        n_checks++;
        if (o_tx_ovf !== 1'b0) $display("FAIL tx_no_ovf: got ovf=%b, required 0", o_tx_ovf);
        else n_pass++;
    endtask

    task automatic test_ovf();
        do_reset();
        goto_run_zero_len();
        busy_stuck = 1'b1;
        for (int i = 0; i <= QD; i++) begin
            if (i < QD) exp_tx.push_back(8'(8'h60 + i));
            @(posedge clk); #1;
            i_core_tx_ready = 1'b1; i_core_sdata = 8'(8'h60 + i);
        end
        @(posedge clk); #1;
        i_core_tx_ready = 1'b0;
        n_checks++;
        if (o_tx_ovf !== 1'b1) $display("FAIL ovf_set: got ovf=%b, required 1", o_tx_ovf);
        else n_pass++;
        busy_stuck = 1'b0;
        for (int c = 0; c < 1000 && exp_tx.size() > 0; c++) @(posedge clk);
        tick(40);
        n_checks++;
        if (exp_tx.size() != 0) $display("FAIL ovf_drain: got %0d bytes unsent, required 0", exp_tx.size());
        else n_pass++;
        n_checks++;
        if (o_tx_ovf !== 1'b1) $display("FAIL ovf_sticky: got ovf=%b, required 1", o_tx_ovf);
        else n_pass++;
    endtask

    task automatic test_reset_mid_load();
        logic [7:0] img[10];
        img = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        do_reset();
        exp_wr.push_back('{addr: 10'd32, data: 32'h44332211});
        for (int i = 0; i < 10; i++) begin send_byte(img[i]); tick(2); end
        n_checks++;
        if (exp_wr.size() != 0) $display("FAIL midload_first_word: got %0d outstanding, required 0", exp_wr.size());
        else n_pass++;
        rstn = 1'b0;
        tick(2);
        @(negedge clk);
        n_checks++;
        if (o_core_rstn !== 1'b0 || o_loading !== 1'b1 || o_bram_we !== 1'b0 || o_bram_addr !== '0 || o_bram_din !== 32'd0)
            $display("FAIL midload_reset: got core_rstn=%b loading=%b we=%b addr=%h din=%h, required 0/1/0/0/0",
                     o_core_rstn, o_loading, o_bram_we, o_bram_addr, o_bram_din);
        else n_pass++;
        rstn = 1'b1;
        for (int i = 0; i < 3; i++) begin send_byte(8'h00); tick(2); end
        send_byte(8'h00);
        @(negedge clk); @(negedge clk);
        n_checks++;
        if (o_core_rstn !== 1'b1) $display("FAIL midload_fresh_len: got core_rstn=%b, required 1", o_core_rstn);
        else n_pass++;
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_load();
        test_zero_len();
        test_passthrough();
        test_tx();
        test_ovf();
        test_reset_mid_load();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
